// File: rtl/edge_centroid_tracker.sv
// edge_centroid_tracker: horizontal centroid of thresholded edge pixels per frame.
// Raster-counts accepted pixels, accumulates column sum and edge count for the
// interior region, and at frame end hands a snapshot to a restoring divider that
// runs while the next frame accumulates.
// Optional feature: define CENTROID_SMOOTH_EN to report a rounded 3:1 IIR of the
// per-frame centroid (one extra cycle of latency).
module edge_centroid_tracker #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int BORDER = 2,
  parameter int THRESH = 8,
  localparam int CW    = $clog2(IMG_W),
  localparam int NW    = $clog2(IMG_W * IMG_H + 1),
  localparam int SUM_W = $clog2((IMG_W - 1) * IMG_W * IMG_H + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    pixel_in,
  input  logic          in_ready,
  input  logic          in_sof,
  output logic [CW-1:0] centroid,
  output logic          centroid_valid,
  output logic          edge_found,
  output logic          busy
);

  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BC_W = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, SMOOTH, REPORT} state_t;

  // Raster position and running accumulators
  logic [CW-1:0]    col_reg;
  logic [RW-1:0]    row_reg;
  logic [SUM_W-1:0] sum_reg;
  logic [NW-1:0]    cnt_reg;

  // Divider state
  state_t           state_reg;
  logic [SUM_W-1:0] dvd_reg;
  logic [NW-1:0]    dsr_reg;
  logic [NW-1:0]    rem_reg;
  logic [CW-2:0]    q_reg;
  logic [BC_W-1:0]  bit_cnt_reg;

  // Combinational pixel path
  logic [CW-1:0]    eff_col, col_next;
  logic [RW-1:0]    eff_row, row_next;
  int               col_i, row_i;
  logic             qualify, frame_end;
  logic [SUM_W-1:0] sum_tot;
  logic [NW-1:0]    cnt_tot;

  // Combinational division step
  logic [NW:0]      rem_shift, rem_diff;
  logic             q_bit;
  logic [NW-1:0]    rem_step;
  logic [CW-1:0]    q_next;

  // Position of the current pixel, edge qualification and end-of-frame totals
  always_comb begin
    eff_col   = in_sof ? '0 : col_reg;
    eff_row   = in_sof ? '0 : row_reg;
    col_i     = int'(eff_col);
    row_i     = int'(eff_row);
    qualify   = in_ready && (int'(pixel_in) >= THRESH) &&
                (col_i >= BORDER) && (col_i < IMG_W - BORDER) &&
                (row_i >= BORDER) && (row_i < IMG_H - BORDER);
    frame_end = in_ready && (eff_col == CW'(IMG_W - 1)) && (eff_row == RW'(IMG_H - 1));
    sum_tot   = (in_sof ? '0 : sum_reg) + (qualify ? {{(SUM_W - CW){1'b0}}, eff_col} : '0);
    cnt_tot   = (in_sof ? '0 : cnt_reg) + (qualify ? NW'(1) : '0);
    if (eff_col == CW'(IMG_W - 1)) begin
      col_next = '0;
      row_next = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + RW'(1);
    end else begin
      col_next = eff_col + CW'(1);
      row_next = eff_row;
    end
  end

  // One restoring-division step; a clear borrow bit means the divisor fits
  always_comb begin
    rem_shift = {rem_reg, dvd_reg[SUM_W-1]};
    rem_diff  = rem_shift - {1'b0, dsr_reg};
    q_bit     = ~rem_diff[NW];
    rem_step  = q_bit ? rem_diff[NW-1:0] : rem_shift[NW-1:0];
    q_next    = {q_reg, q_bit};
  end

  // Raster counters and accumulators; cleared on the frame-end edge so the next frame has no gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
      sum_reg <= '0;
      cnt_reg <= '0;
    end else if (in_ready) begin
      col_reg <= col_next;
      row_reg <= row_next;
      if (frame_end) begin
        sum_reg <= '0;
        cnt_reg <= '0;
      end else begin
        sum_reg <= sum_tot;
        cnt_reg <= cnt_tot;
      end
    end
  end

`ifdef CENTROID_SMOOTH_EN
  logic          primed_reg;
  logic [CW-1:0] q_raw_reg;
  logic [CW+2:0] smooth_sum;
  logic [CW-1:0] smooth_val;

  // Rounded 3:1 blend of the previous report with the new quotient
  always_comb begin
    smooth_sum = ({3'b000, centroid} << 1) + {3'b000, centroid} +
                 {3'b000, q_raw_reg} + (CW + 3)'(2);
    smooth_val = smooth_sum[CW+1:2];
  end
`endif

  // Divider/report FSM; a new frame end always wins and restarts with the newest snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      dvd_reg        <= '0;
      dsr_reg        <= '0;
      rem_reg        <= '0;
      q_reg          <= '0;
      bit_cnt_reg    <= '0;
      centroid       <= '0;
      centroid_valid <= 1'b0;
      edge_found     <= 1'b0;
      busy           <= 1'b0;
`ifdef CENTROID_SMOOTH_EN
      primed_reg     <= 1'b0;
      q_raw_reg      <= '0;
`endif
    end else begin
      centroid_valid <= 1'b0;
      if (frame_end) begin
        dvd_reg     <= sum_tot;
        dsr_reg     <= cnt_tot;
        rem_reg     <= '0;
        q_reg       <= '0;
        bit_cnt_reg <= BC_W'(SUM_W - 1);
        if (cnt_tot != '0) begin
          state_reg <= DIVIDE;
          busy      <= 1'b1;
        end else begin
          state_reg      <= REPORT;
          busy           <= 1'b0;
          centroid_valid <= 1'b1;
          edge_found     <= 1'b0;
        end
      end else begin
        case (state_reg)
          DIVIDE: begin
            dvd_reg     <= {dvd_reg[SUM_W-2:0], 1'b0};
            rem_reg     <= rem_step;
            q_reg       <= q_next[CW-2:0];
            bit_cnt_reg <= bit_cnt_reg - BC_W'(1);
            if (bit_cnt_reg == '0) begin
              busy <= 1'b0;
`ifdef CENTROID_SMOOTH_EN
              q_raw_reg <= q_next;
              state_reg <= SMOOTH;
`else
              centroid       <= q_next;
              edge_found     <= 1'b1;
              centroid_valid <= 1'b1;
              state_reg      <= REPORT;
`endif
            end
          end
          SMOOTH: begin
`ifdef CENTROID_SMOOTH_EN
            centroid   <= primed_reg ? smooth_val : q_raw_reg;
            primed_reg <= 1'b1;
`endif
            edge_found     <= 1'b1;
            centroid_valid <= 1'b1;
            state_reg      <= REPORT;
          end
          REPORT:  state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_centroid_tracker.sv
// tb_edge_centroid_tracker: drives two tracker instances (BORDER=0 and BORDER=1)
// with the same 8x4 pixel stream and compares each reported frame against a
// frame-level reference model (sum of qualifying columns / edge count).
module tb_edge_centroid_tracker;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int TH    = 8;
  localparam int NPIX  = W * H;
  localparam int CW_T  = $clog2(W);
  localparam int SUM_W = $clog2((W - 1) * W * H + 1);
`ifdef CENTROID_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
  localparam int EXTRA  = 1;
`else
  localparam bit SMOOTH = 1'b0;
  localparam int EXTRA  = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      pixel_in;
  logic            in_ready;
  logic            in_sof;
  logic [CW_T-1:0] cent0, cent1;
  logic            val0, val1, edge0, edge1, busy0, busy1;

  edge_centroid_tracker #(.IMG_W(W), .IMG_H(H), .BORDER(0), .THRESH(TH)) dut_b0 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready), .in_sof(in_sof),
    .centroid(cent0), .centroid_valid(val0), .edge_found(edge0), .busy(busy0)
  );

  edge_centroid_tracker #(.IMG_W(W), .IMG_H(H), .BORDER(1), .THRESH(TH)) dut_b1 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready), .in_sof(in_sof),
    .centroid(cent1), .centroid_valid(val1), .edge_found(edge1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Pulse/busy event recorder
  int ev_cyc0[$], ev_cen0[$], ev_edg0[$];
  int ev_cyc1[$], ev_cen1[$], ev_edg1[$];
  int busy_q[$];

  always @(negedge clk) begin
    if (val0 === 1'b1) begin
      ev_cyc0.push_back(cyc); ev_cen0.push_back(int'(cent0)); ev_edg0.push_back(int'(edge0));
    end
    if (val1 === 1'b1) begin
      ev_cyc1.push_back(cyc); ev_cen1.push_back(int'(cent1)); ev_edg1.push_back(int'(edge1));
    end
    if (busy0 === 1'b1) busy_q.push_back(cyc);
  end

  task automatic clear_events();
    ev_cyc0.delete(); ev_cen0.delete(); ev_edg0.delete();
    ev_cyc1.delete(); ev_cen1.delete(); ev_edg1.delete();
    busy_q.delete();
  endtask

  // Reference model state
  logic [3:0] frame_pix [NPIX];
  int         prev_c [2];
  bit         primed [2];

  task automatic clear_frame();
    for (int i = 0; i < NPIX; i++) frame_pix[i] = 4'd0;
  endtask

  task automatic set_px(input int c, input int r, input int v);
    frame_pix[r * W + c] = 4'(v);
  endtask

  // Column sum and count of edge pixels inside the border margin
  task automatic ref_frame(input int border, output int s, output int n);
    s = 0; n = 0;
    for (int p = 0; p < NPIX; p++) begin
      if (int'(frame_pix[p]) >= TH && (p % W) >= border && (p % W) < W - border &&
          (p / W) >= border && (p / W) < H - border) begin
        s += p % W;
        n++;
      end
    end
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_ready = 1'b0;
      in_sof   = 1'(($urandom_range(0, 1)));
      pixel_in = 4'($urandom_range(0, 15));
    end
  endtask

  // Send frame_pix as one full frame, with random stall cycles between accepted pixels
  task automatic send_pixels(input int ready_pct, input bit sof_first, output int t_last);
    t_last = 0;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      while ($urandom_range(0, 99) >= ready_pct) begin
        in_ready = 1'b0;
        in_sof   = 1'(($urandom_range(0, 1)));
        pixel_in = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      in_ready = 1'b1;
      in_sof   = sof_first && (i == 0);
      pixel_in = frame_pix[i];
      t_last   = cyc;
    end
  endtask

  // Partial frame that a following in_sof must discard
  task automatic send_junk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_ready = 1'b1;
      in_sof   = 1'b0;
      pixel_in = ($urandom_range(0, 3) != 0) ? 4'd15 : 4'($urandom_range(0, 15));
    end
  endtask

  task automatic run_frame(input string name, input int ready_pct, input bit sof_first);
    int t, s, n, q, exp_c, lat, n0;
    int qc[$], qv[$], qe[$];
    send_pixels(ready_pct, sof_first, t);
    while (cyc < t + SUM_W + EXTRA + 4) drive_idle(1);
    n0 = 0;
    for (int d = 0; d < 2; d++) begin
      ref_frame(d, s, n);
      if (d == 0) n0 = n;
      if (n != 0) begin
        q     = s / n;
        exp_c = (SMOOTH && primed[d]) ? ((3 * prev_c[d] + q + 2) >> 2) : q;
        primed[d] = 1'b1;
        lat   = SUM_W + 1 + EXTRA;
      end else begin
        exp_c = prev_c[d];
        lat   = 1;
      end
      if (d == 0) begin qc = ev_cyc0; qv = ev_cen0; qe = ev_edg0; end
      else        begin qc = ev_cyc1; qv = ev_cen1; qe = ev_edg1; end
      check($sformatf("%s/b%0d/pulses", name, d), qc.size(), 1);
      if (qc.size() > 0) begin
        check($sformatf("%s/b%0d/pulse_cycle", name, d), qc[0], t + lat);
        check($sformatf("%s/b%0d/centroid", name, d), qv[0], exp_c);
        check($sformatf("%s/b%0d/edge_found", name, d), qe[0], (n != 0) ? 1 : 0);
      end
      prev_c[d] = exp_c;
    end
    check($sformatf("%s/busy_cycles", name), busy_q.size(), (n0 != 0) ? SUM_W : 0);
    if (busy_q.size() > 0) begin
      check($sformatf("%s/busy_first", name), busy_q[0], t + 1);
      check($sformatf("%s/busy_last", name), busy_q[busy_q.size() - 1], t + SUM_W);
    end
    $display("frame %s t=%0d b0=%0d b1=%0d", name, t, prev_c[0], prev_c[1]);
    clear_events();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "/b0/centroid"}, int'(cent0), 0);
    check({name, "/b0/valid"},    int'(val0),  0);
    check({name, "/b0/edge"},     int'(edge0), 0);
    check({name, "/b0/busy"},     int'(busy0), 0);
    check({name, "/b1/centroid"}, int'(cent1), 0);
    check({name, "/b1/busy"},     int'(busy1), 0);
  endtask

  initial begin
    int t;
    rst = 1'b1; in_ready = 1'b0; in_sof = 1'b0; pixel_in = 4'd0;
    prev_c[0] = 0; prev_c[1] = 0; primed[0] = 1'b0; primed[1] = 1'b0;

    // Reset held with random inputs
    repeat (8) begin
      @(negedge clk);
      in_ready = 1'(($urandom_range(0, 1)));
      in_sof   = 1'(($urandom_range(0, 1)));
      pixel_in = 4'($urandom_range(0, 15));
    end
    check_outputs_zero("reset_hold");
    @(negedge clk);
    in_ready = 1'b0; in_sof = 1'b0;
    rst = 1'b0;
    drive_idle(2);

    // Reset asserted in the middle of a division
    clear_frame(); set_px(2, 1, 15); set_px(5, 1, 15);
    send_pixels(100, 1'b0, t);
    while (cyc < t + 4) drive_idle(1);
    check("mid_div/busy_before_reset", int'(busy0), 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_div_reset");
    drive_idle(2);
    rst = 1'b0;
    drive_idle(SUM_W + 6);
    check("mid_div/no_pulse_b0", ev_cyc0.size(), 0);
    check("mid_div/no_pulse_b1", ev_cyc1.size(), 0);
    $display("reset mid-division checked at cycle %0d", cyc);
    clear_events();
    prev_c[0] = 0; prev_c[1] = 0; primed[0] = 1'b0; primed[1] = 1'b0;

    // Two edge pixels, continuous input
    clear_frame(); set_px(2, 1, 15); set_px(5, 1, 15);
    run_frame("two_px", 100, 1'b0);

    // All-zero frame holds the previous centroid
    clear_frame();
    run_frame("zero", 100, 1'b0);

    // Same two pixels with about half the cycles stalled
    clear_frame(); set_px(2, 1, 15); set_px(5, 1, 15);
    run_frame("two_px_stall", 50, 1'b0);

    // Border exclusion and sub-threshold pixel
    clear_frame(); set_px(0, 2, 15); set_px(6, 2, 15); set_px(3, 2, 7);
    run_frame("border", 100, 1'b0);

    // in_sof after 10 junk pixels restarts the frame
    send_junk(10);
    clear_frame(); set_px(3, 0, 15); set_px(5, 3, 15);
    run_frame("sof_restart", 100, 1'b1);

    // Raw centroid 4 then 0
    clear_frame(); set_px(4, 1, 15); set_px(4, 2, 15);
    run_frame("raw4", 100, 1'b0);
    clear_frame(); set_px(0, 1, 15);
    run_frame("raw0", 100, 1'b0);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      int pct;
      bit sof;
      clear_frame();
      if ($urandom_range(0, 5) != 0) begin
        for (int p = 0; p < NPIX; p++)
          frame_pix[p] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15))
                                                     : 4'($urandom_range(0, 7));
      end
      pct = ($urandom_range(0, 2) == 0) ? 100 : int'($urandom_range(40, 90));
      sof = 1'(($urandom_range(0, 2) == 0));
      if (sof && $urandom_range(0, 1) == 1) send_junk(int'($urandom_range(1, 20)));
      run_frame($sformatf("rand%0d", f), pct, sof);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d expected=%0d", cyc, 0);
    $fatal(1, "simulation time limit reached");
  end

endmodule
